// File: rtl/vga_timing_out.sv
// vga_timing_out: free-running 640x480@60 VGA timing generator with the output
// packing stage for the Tiny VGA PMOD. Raw hsync/vsync/display_on are delayed
// PIPE_DELAY clocks to line up with the renderer colour, then registered onto
// uo_out with forced blanking outside the visible window.
// Optional build macro: TEST_PATTERN_EN (internal colour bars selected by test_sel).
module vga_timing_out #(
   parameter int unsigned H_DISPLAY  = 640,
   parameter int unsigned H_FRONT    = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BACK     = 48,
   parameter int unsigned V_DISPLAY  = 480,
   parameter int unsigned V_FRONT    = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BACK     = 33,
   parameter int unsigned PIPE_DELAY = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] rrggbb_in,
   input  logic       test_sel,
   output logic [9:0] hpos,
   output logic [9:0] vpos,
   output logic       display_on,
   output logic       line_start,
   output logic       frame_start,
   output logic [7:0] uo_out
);

   localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
   localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);
   localparam logic [9:0] HS_BEG = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] HS_END = 10'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_BEG = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] VS_END = 10'(V_DISPLAY + V_FRONT + V_SYNC);

   // Tap word carried through the alignment pipe:
   // [0]=display_on [1]=vsync [2]=hsync, plus [4:3]=hpos[8:7] for the colour bars.
`ifdef TEST_PATTERN_EN
   localparam int unsigned TW = 5;
`else
   localparam int unsigned TW = 3;
`endif
   // Idle tap: both syncs deasserted (high), blanked.
   localparam logic [TW-1:0] TAP_IDLE = TW'(3'b110);

   logic [9:0]    h_q, h_d;
   logic [9:0]    v_q, v_d;
   logic [TW-1:0] tap_raw;
   logic [TW-1:0] tap_dly;
   logic [5:0]    colour_src;
   logic [5:0]    colour;
   logic [7:0]    uo_q, uo_d;

   // Next counter values: h wraps every line, v advances on the h wrap
   always_comb begin
      h_d = h_q + 10'd1;
      v_d = v_q;
      if (h_q == H_LAST) begin
         h_d = '0;
         v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end
   end

   // Position counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   assign hpos        = h_q;
   assign vpos        = v_q;
   assign display_on  = (h_q < H_VIS) && (v_q < V_VIS);
   assign line_start  = (h_q == '0);
   assign frame_start = (h_q == '0) && (v_q == '0);

   // Undelayed sync/blank tap for the current counter position
   always_comb begin
      tap_raw    = TAP_IDLE;
      tap_raw[2] = ~((h_q >= HS_BEG) && (h_q < HS_END));
      tap_raw[1] = ~((v_q >= VS_BEG) && (v_q < VS_END));
      tap_raw[0] = display_on;
`ifdef TEST_PATTERN_EN
      tap_raw[4:3] = h_q[8:7];
`endif
   end

   generate
      if (PIPE_DELAY == 0) begin : g_no_delay
         assign tap_dly = tap_raw;
      end else begin : g_delay
         for (genvar g = 0; g < int'(PIPE_DELAY); g++) begin : g_stage
            logic [TW-1:0] d;
            logic [TW-1:0] q;
            if (g == 0) begin : g_in
               assign d = tap_raw;
            end else begin : g_in
               assign d = g_stage[g-1].q;
            end
            // One alignment stage; reset flushes it to idle syncs and blanking
            always_ff @(posedge clk) begin
               if (reset) q <= TAP_IDLE;
               else       q <= d;
            end
         end
         assign tap_dly = g_stage[PIPE_DELAY-1].q;
      end
   endgenerate

   // Select colour source, blank outside the delayed window, pack PMOD pin order
   always_comb begin
      colour_src = rrggbb_in;
`ifdef TEST_PATTERN_EN
      if (test_sel) colour_src = {3{tap_dly[4:3]}};
`endif
      colour = tap_dly[0] ? colour_src : '0;
      uo_d   = {tap_dly[2], colour[0], colour[2], colour[4],
                tap_dly[1], colour[1], colour[3], colour[5]};
   end

   // Output pin register; reset shows deasserted syncs and black
   always_ff @(posedge clk) begin
      if (reset) uo_q <= 8'h88;
      else       uo_q <= uo_d;
   end

   assign uo_out = uo_q;

`ifndef TEST_PATTERN_EN
   logic unused_test_sel;
   assign unused_test_sel = test_sel;
`endif

endmodule
